// File: rtl/commit_trace_buffer_if.sv
// Commit-side and trace-read-side signal bundle for commit_trace_buffer.
// The timestamp output rd_cycle exists only when TRACE_TIMESTAMP_EN is defined.
interface commit_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
);
  logic              cm_valid;
  logic [ADDR_W-1:0] cm_pc;
  logic              cm_regwrite;
  logic [REG_W-1:0]  cm_wreg;
  logic [DATA_W-1:0] cm_wdata;
  logic              cm_memread;
  logic              cm_memwrite;
  logic [ADDR_W-1:0] cm_memaddr;
  logic [DATA_W-1:0] cm_memdata;
  logic              cm_halt;

  logic              rd_valid;
  logic              rd_ready;
  logic [2:0]        rd_kind;
  logic [CNT_W-1:0]  rd_inum;
  logic [ADDR_W-1:0] rd_pc;
  logic [REG_W-1:0]  rd_wreg;
  logic [DATA_W-1:0] rd_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_mdata;
`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0]  rd_cycle;
`endif

  modport master (
    output cm_valid, cm_pc, cm_regwrite, cm_wreg, cm_wdata, cm_memread,
           cm_memwrite, cm_memaddr, cm_memdata, cm_halt, rd_ready,
    input  rd_valid, rd_kind, rd_inum, rd_pc, rd_wreg, rd_wdata, rd_addr, rd_mdata
`ifdef TRACE_TIMESTAMP_EN
    , input rd_cycle
`endif
  );

  modport slave (
    input  cm_valid, cm_pc, cm_regwrite, cm_wreg, cm_wdata, cm_memread,
           cm_memwrite, cm_memaddr, cm_memdata, cm_halt, rd_ready,
    output rd_valid, rd_kind, rd_inum, rd_pc, rd_wreg, rd_wdata, rd_addr, rd_mdata
`ifdef TRACE_TIMESTAMP_EN
    , output rd_cycle
`endif
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retirement trace recorder: classifies commits, numbers them and queues them in a FIFO.
// Optional per-entry commit timestamp (rd_cycle) enabled by TRACE_TIMESTAMP_EN.
module commit_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  commit_trace_buffer_if.slave bus,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             halted,
  output logic             done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [2:0] K_NOP = 3'd0, K_REG = 3'd1, K_LD = 3'd2,
                         K_ST  = 3'd3, K_STU = 3'd4, K_HALT = 3'd5;

  typedef enum logic [1:0] {S_RUN, S_HALT_PEND, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]        kind;
    logic [CNT_W-1:0]  inum;
    logic [ADDR_W-1:0] pc;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0]  cycle;
`endif
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  state_t           r_state, w_state_next;
  entry_t           r_pend;
  logic [CNT_W-1:0] r_cycle, r_inst, r_drop;
  logic             r_overflow, r_halted;

  entry_t w_new, w_head, w_push_data;
  logic   w_full, w_pop, w_commit, w_commit_halt, w_blocked, w_push, w_drop;

  assign w_full        = (r_count == (PTR_W+1)'(DEPTH));
  assign w_pop         = (r_count != '0) && bus.rd_ready;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_commit      = bus.cm_valid && (r_state == S_RUN);
  assign w_commit_halt = w_commit && bus.cm_halt;
  // A full FIFO can still take a push on the same edge that it pops.
  assign w_blocked     = w_full && !w_pop;

  // Classify the commit; fields not meaningful for the kind stay zero.
  always_comb begin
    w_new      = '0;
    w_new.inum = r_inst;
    w_new.pc   = bus.cm_pc;
`ifdef TRACE_TIMESTAMP_EN
    w_new.cycle = r_cycle;
`endif
    if (bus.cm_halt) begin
      w_new.kind = K_HALT;
    end else if (bus.cm_regwrite && bus.cm_memwrite) begin
      w_new.kind  = K_STU;
      w_new.wreg  = bus.cm_wreg;
      w_new.wdata = bus.cm_wdata;
      w_new.addr  = bus.cm_memaddr;
      w_new.mdata = bus.cm_memdata;
    end else if (bus.cm_regwrite && bus.cm_memread) begin
      w_new.kind  = K_LD;
      w_new.wreg  = bus.cm_wreg;
      w_new.wdata = bus.cm_wdata;
      w_new.addr  = bus.cm_memaddr;
    end else if (bus.cm_regwrite) begin
      w_new.kind  = K_REG;
      w_new.wreg  = bus.cm_wreg;
      w_new.wdata = bus.cm_wdata;
    end else if (bus.cm_memwrite) begin
      w_new.kind  = K_ST;
      w_new.addr  = bus.cm_memaddr;
      w_new.mdata = bus.cm_memdata;
    end else begin
      w_new.kind = K_NOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:       if (w_commit_halt) w_state_next = w_blocked ? S_HALT_PEND : S_DRAIN;
      S_HALT_PEND: if (!w_blocked) w_state_next = S_DRAIN;
      S_DRAIN:     if (w_pop && (w_head.kind == K_HALT)) w_state_next = S_DONE;
      default:     w_state_next = S_DONE;
    endcase
  end

  always_comb begin
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_push_data = w_new;
    case (r_state)
      S_RUN: begin
        if (w_commit) begin
          if (!w_blocked)        w_push = 1'b1;
          else if (!bus.cm_halt) w_drop = 1'b1;
        end
      end
      S_HALT_PEND: begin
        w_push_data = r_pend;
        w_push      = !w_blocked;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_cycle    <= '0;
      r_inst     <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if ((r_state != S_DONE) && (r_cycle != '1)) r_cycle <= r_cycle + 1'b1;
      if (w_commit) r_inst <= r_inst + 1'b1;
      if (w_commit_halt) r_halted <= 1'b1;
      if (w_commit_halt && w_blocked) r_pend <= w_new;
      if (w_drop) begin
        r_drop     <= r_drop + 1'b1;
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign bus.rd_valid = (r_count != '0);
  assign bus.rd_kind  = w_head.kind;
  assign bus.rd_inum  = w_head.inum;
  assign bus.rd_pc    = w_head.pc;
  assign bus.rd_wreg  = w_head.wreg;
  assign bus.rd_wdata = w_head.wdata;
  assign bus.rd_addr  = w_head.addr;
  assign bus.rd_mdata = w_head.mdata;
`ifdef TRACE_TIMESTAMP_EN
  assign bus.rd_cycle = w_head.cycle;
`endif

  assign cycle_count = r_cycle;
  assign inst_count  = r_inst;
  assign drop_count  = r_drop;
  assign overflow    = r_overflow;
  assign halted      = r_halted;
  assign done        = (r_state == S_DONE);
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a 4-entry FIFO.
module tb_commit_trace_buffer;
  localparam int DATA_W = 16, ADDR_W = 16, REG_W = 3, DEPTH = 4, CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] cycle_count, inst_count, drop_count;
  logic overflow, halted, done;
  int n_cmp = 0, n_bad = 0, cyc = 0, cyc_done = 0;

  commit_trace_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  commit_trace_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
    .overflow(overflow), .halted(halted), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic h, input logic rw, input logic mr, input logic mw,
                       input logic [15:0] pc, input logic [2:0] wreg, input logic [15:0] wdata,
                       input logic [15:0] addr, input logic [15:0] mdata);
    bus.cm_valid    = v;
    bus.cm_halt     = h;
    bus.cm_regwrite = rw;
    bus.cm_memread  = mr;
    bus.cm_memwrite = mw;
    bus.cm_pc       = pc;
    bus.cm_wreg     = wreg;
    bus.cm_wdata    = wdata;
    bus.cm_memaddr  = addr;
    bus.cm_memdata  = mdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic check_head(input string tag, input logic [2:0] kind, input logic [31:0] inum,
                            input logic [15:0] pc, input logic [2:0] wreg, input logic [15:0] wdata,
                            input logic [15:0] addr, input logic [15:0] mdata);
    $display("head %s: kind=%0d inum=%0d pc=%h wreg=%0d wdata=%h addr=%h mdata=%h", tag,
             bus.rd_kind, bus.rd_inum, bus.rd_pc, bus.rd_wreg, bus.rd_wdata, bus.rd_addr, bus.rd_mdata);
    chk({tag, ".valid"}, 64'(bus.rd_valid), 64'd1);
    chk({tag, ".kind"},  64'(bus.rd_kind),  64'(kind));
    chk({tag, ".inum"},  64'(bus.rd_inum),  64'(inum));
    chk({tag, ".pc"},    64'(bus.rd_pc),    64'(pc));
    chk({tag, ".wreg"},  64'(bus.rd_wreg),  64'(wreg));
    chk({tag, ".wdata"}, 64'(bus.rd_wdata), 64'(wdata));
    chk({tag, ".addr"},  64'(bus.rd_addr),  64'(addr));
    chk({tag, ".mdata"}, 64'(bus.rd_mdata), 64'(mdata));
  endtask

  initial begin
    idle();
    bus.rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    $display("reset released");
    chk("rst.valid", 64'(bus.rd_valid), 64'd0);
    chk("rst.cycle", 64'(cycle_count), 64'd0);
    chk("rst.inst", 64'(inst_count), 64'd0);
    chk("rst.drop", 64'(drop_count), 64'd0);
    chk("rst.flags", {61'd0, overflow, halted, done}, 64'd0);

    // REG, LD, ST back to back with the consumer always ready
    bus.rd_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 3'd3, 16'h00AA, 16'h0099, 16'h0077);
    tick();
    check_head("reg", 3'd1, 0, 16'h0002, 3'd3, 16'h00AA, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 3'd1, 16'h0BEE, 16'h0010, 16'h7777);
    tick();
    check_head("ld", 3'd2, 1, 16'h0004, 3'd1, 16'h0BEE, 16'h0010, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0006, 3'd6, 16'hDEAD, 16'h0012, 16'h1234);
    tick();
    check_head("st", 3'd3, 2, 16'h0006, 3'd0, 16'h0000, 16'h0012, 16'h1234);
    idle();
    tick();
    chk("drained.valid", 64'(bus.rd_valid), 64'd0);
    chk("drained.inst", 64'(inst_count), 64'd3);
    chk("drained.cycle", 64'(cycle_count), 64'(cyc));

    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0008, 3'd2, 16'h0008, 16'h0008, 16'h5555);
    tick();
    check_head("stu", 3'd4, 3, 16'h0008, 3'd2, 16'h0008, 16'h0008, 16'h5555);
    idle();
    tick();
    chk("stu.popped", 64'(bus.rd_valid), 64'd0);

    // three entries queued, then asynchronous reset between edges
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0030 + 2*i), 3'(i), 16'(16'h0200 + i), 16'h0, 16'h0);
      tick();
    end
    idle();
    chk("pre_rst.valid", 64'(bus.rd_valid), 64'd1);
    chk("pre_rst.inst", 64'(inst_count), 64'd7);
    chk("pre_rst.inum", 64'(bus.rd_inum), 64'd4);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted mid-cycle");
    chk("arst.valid", 64'(bus.rd_valid), 64'd0);
    chk("arst.inst", 64'(inst_count), 64'd0);
    chk("arst.cycle", 64'(cycle_count), 64'd0);
    chk("arst.drop", 64'(drop_count), 64'd0);
    chk("arst.flags", {61'd0, overflow, halted, done}, 64'd0);
    #1;
    rst = 1'b0;
    cyc = 0;

    // overflow: six commits into four slots with no consumer
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0040 + 2*i), 3'(i), 16'(16'h0100 + i), 16'h0, 16'h0);
      tick();
    end
    idle();
    chk("ovf.inst", 64'(inst_count), 64'd6);
    chk("ovf.drop", 64'(drop_count), 64'd2);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.cycle", 64'(cycle_count), 64'(cyc));
    check_head("ovf", 3'd1, 0, 16'h0040, 3'd0, 16'h0100, 16'h0, 16'h0);

    // full with simultaneous push and pop
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0060, 3'd7, 16'h0777, 16'h0, 16'h0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    idle();
    chk("fullpp.inst", 64'(inst_count), 64'd7);
    chk("fullpp.drop", 64'(drop_count), 64'd2);
    check_head("fullpp", 3'd1, 1, 16'h0042, 3'd1, 16'h0101, 16'h0, 16'h0);

    // HALT while full: held pending, never dropped
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 3'd5, 16'h0BAD, 16'h0, 16'h0);
    tick();
    chk("hpend.halted", 64'(halted), 64'd1);
    chk("hpend.inst", 64'(inst_count), 64'd8);
    chk("hpend.drop", 64'(drop_count), 64'd2);
    chk("hpend.done", 64'(done), 64'd0);
    chk("hpend.inum", 64'(bus.rd_inum), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0070, 3'd4, 16'h0444, 16'h0, 16'h0);
    tick();
    idle();
    chk("ignored.inst", 64'(inst_count), 64'd8);
    chk("ignored.drop", 64'(drop_count), 64'd2);

    bus.rd_ready = 1'b1;
    tick();
    check_head("drain2", 3'd1, 2, 16'h0044, 3'd2, 16'h0102, 16'h0, 16'h0);
    tick();
    check_head("drain3", 3'd1, 3, 16'h0046, 3'd3, 16'h0103, 16'h0, 16'h0);
    tick();
    check_head("drain6", 3'd1, 6, 16'h0060, 3'd7, 16'h0777, 16'h0, 16'h0);
    tick();
    check_head("halt", 3'd5, 7, 16'h0020, 3'd0, 16'h0000, 16'h0, 16'h0);
    chk("halt.done", 64'(done), 64'd0);
    tick();
    chk("done.done", 64'(done), 64'd1);
    chk("done.valid", 64'(bus.rd_valid), 64'd0);
    chk("done.cycle", 64'(cycle_count), 64'(cyc));
    cyc_done = cyc;

    // commits after DONE are ignored and the cycle counter freezes
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080, 3'd1, 16'h0011, 16'h0, 16'h0);
    tick();
    tick();
    idle();
    $display("post-done commits applied");
    chk("post.inst", 64'(inst_count), 64'd8);
    chk("post.valid", 64'(bus.rd_valid), 64'd0);
    chk("post.cycle", 64'(cycle_count), 64'(cyc_done));
    chk("post.done", 64'(done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
